// File: rtl/bikelight_pkg.sv
// Shared mode encodings and counter-width helper for the bike light controller.
package bikelight_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_OFF   = 2'd0;
  localparam logic [MODE_W-1:0] MODE_ON    = 2'd1;
  localparam logic [MODE_W-1:0] MODE_BLINK = 2'd2;
  localparam logic [MODE_W-1:0] MODE_DIM   = 2'd3;

  typedef enum logic [MODE_W-1:0] {
    ST_OFF   = MODE_OFF,
    ST_ON    = MODE_ON,
    ST_BLINK = MODE_BLINK,
    ST_DIM   = MODE_DIM
  } mode_t;

  // Width of a counter that runs 0..terminal-1; never narrower than one bit.
  function automatic int cnt_w(input int terminal);
    return (terminal < 2) ? 1 : $clog2(terminal);
  endfunction

endpackage

// File: rtl/bikelight_debounce.sv
// Button front end: 2-flop synchronizer, level debouncer and rising-edge press pulse.
module bikelight_debounce #(
  parameter int DB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int              CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          db;
  logic          db_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db    <= 1'b0;
      db_q  <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      // synchronizer stage
      sync1 <= btn;
      sync2 <= sync1;
      // debounce stage: the DB_CYCLES-th disagreeing sample flips the level
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // edge stage: only a rising debounced level is a press
      db_q  <= db;
      press <= db & ~db_q;
    end
  end

endmodule

// File: rtl/bikelight_ctrl.sv
// Bike light mode controller: debounced button steps OFF/ON/BLINK[/DIM] and drives the LED.
// Define BIKELIGHT_DIM_EN to build the DIM mode and its PWM counter.
module bikelight_ctrl
  import bikelight_pkg::*;
#(
  parameter int DB_CYCLES  = 3,
  parameter int BLINK_HALF = 8,
  parameter int PWM_PERIOD = 4,
  parameter int PWM_DUTY   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn,
  output logic              led,
  output logic [MODE_W-1:0] mode,
  output logic              press
);

  localparam int            BW         = cnt_w(BLINK_HALF);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  mode_t         state;
  mode_t         state_nxt;
  logic          mode_chg;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic          pwm_on;

  bikelight_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn),
    .press(press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_OFF;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:   if (press) state_nxt = ST_ON;
      ST_ON:    if (press) state_nxt = ST_BLINK;
`ifdef BIKELIGHT_DIM_EN
      ST_BLINK: if (press) state_nxt = ST_DIM;
      ST_DIM:   if (press) state_nxt = ST_OFF;
`else
      ST_BLINK: if (press) state_nxt = ST_OFF;
      // code 3 is unreachable here; treat it as OFF
      ST_DIM:   state_nxt = press ? ST_ON : ST_OFF;
`endif
      default:  state_nxt = ST_OFF;
    endcase
  end

  assign mode     = state;
  assign mode_chg = (state_nxt != state);

  // A mode change outranks a same-cycle blink wrap and restarts the phase high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else if (mode_chg) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

`ifdef BIKELIGHT_DIM_EN
  localparam int            PW       = cnt_w(PWM_PERIOD);
  localparam logic [PW-1:0] PWM_LAST = PW'(PWM_PERIOD - 1);

  logic [PW-1:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   pwm_cnt <= '0;
    else if (pwm_cnt == PWM_LAST) pwm_cnt <= '0;
    else                          pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign pwm_on = (pwm_cnt < PW'(PWM_DUTY));
`else
  localparam bit PWM_CFG_OK = (PWM_DUTY < PWM_PERIOD);

  assign pwm_on = PWM_CFG_OK & 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= 1'b0;
    end else begin
      case (state)
        ST_ON:    led <= 1'b1;
        ST_BLINK: led <= blink_ph;
        ST_DIM:   led <= pwm_on;
        default:  led <= 1'b0;
      endcase
    end
  end

endmodule
